// File: rtl/eth_10g_cfg_sequencer.sv
// eth_10g_cfg_sequencer
//   AXI4-Lite master that programs NUM_REGS consecutive 32-bit registers of the
//   eth_10g register slave (BASE_ADDR + 4*i, ascending). It can optionally read
//   each register back and compare it, and it reports done/error status.
// Ports
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   start, verify_en       one-cycle request (accepted only when idle), readback enable
//   cfg_data               word i at bits [32*i+31:32*i], captured on accepted start
//   busy, done, error      status; done/error/err_* hold until the next accepted start
//   err_code, err_index    0 none, 1 bad BRESP, 2 bad RRESP or mismatch, 3 timeout; failing index
//   m_axi_*                AXI4-Lite master (one outstanding transaction at a time)
module eth_10g_cfg_sequencer #(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter int                            NUM_REGS           = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
  parameter int                            TIMEOUT_CYCLES     = 255
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            start,
  input  logic                            verify_en,
  input  logic [NUM_REGS*32-1:0]          cfg_data,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [1:0]                      err_code,
  output logic [3:0]                      err_index,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                      m_axi_awprot,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                      m_axi_arprot,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0]  LAST_IDX  = 4'(NUM_REGS - 1);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA, ST_NEXT, ST_FIN
  } state_t;

  state_t      state;
  logic [31:0] words [NUM_REGS];
  logic        verify_q;
  logic [3:0]  idx;
  logic [3:0]  idx_inc;
  logic [15:0] timer;
  logic [31:0] cur_word;
  logic [31:0] next_word;
  logic        aw_ok, w_ok, b_fire, ar_fire, r_fire, timeout_hit;
  logic        abort_req;
  logic [1:0]  abort_code;

  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wstrb  = '1;

  assign idx_inc   = idx + 4'd1;
  assign cur_word  = words[idx[IDX_W-1:0]];
  // Only consumed in NEXT when idx is not the last register.
  assign next_word = words[idx_inc[IDX_W-1:0]];

  // A write channel is finished once its valid has dropped or is handshaking now.
  assign aw_ok       = !m_axi_awvalid || m_axi_awready;
  assign w_ok        = !m_axi_wvalid  || m_axi_wready;
  assign b_fire      = m_axi_bvalid  && m_axi_bready;
  assign ar_fire     = m_axi_arvalid && m_axi_arready;
  assign r_fire      = m_axi_rvalid  && m_axi_rready;
  assign timeout_hit = (timer == TMO_LAST);

  function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] reg_addr(input logic [3:0] i);
    return BASE_ADDR + C_M_AXI_ADDR_WIDTH'({i, 2'b00});
  endfunction

  // Abort decision; a completing handshake always wins over the timeout.
  always_comb begin
    abort_req  = 1'b0;
    abort_code = 2'd0;
    case (state)
      ST_WR: begin
        if (!(aw_ok && w_ok) && timeout_hit) begin
          abort_req  = 1'b1;
          abort_code = 2'd3;
        end
      end
      ST_WR_RESP: begin
        if (b_fire) begin
          if (m_axi_bresp != 2'b00) begin
            abort_req  = 1'b1;
            abort_code = 2'd1;
          end
        end else if (timeout_hit) begin
          abort_req  = 1'b1;
          abort_code = 2'd3;
        end
      end
      ST_RD_ADDR: begin
        if (!ar_fire && timeout_hit) begin
          abort_req  = 1'b1;
          abort_code = 2'd3;
        end
      end
      ST_RD_DATA: begin
        if (r_fire) begin
          if (m_axi_rresp != 2'b00 || m_axi_rdata != cur_word) begin
            abort_req  = 1'b1;
            abort_code = 2'd2;
          end
        end else if (timeout_hit) begin
          abort_req  = 1'b1;
          abort_code = 2'd3;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= ST_IDLE;
      verify_q      <= 1'b0;
      idx           <= '0;
      timer         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_code      <= '0;
      err_index     <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) words[i] <= '0;
    end else if (abort_req) begin
      // Drop every valid/ready at once; nothing more is issued.
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      error         <= 1'b1;
      err_code      <= abort_code;
      err_index     <= idx;
      busy          <= 1'b0;
      done          <= 1'b1;
      state         <= ST_FIN;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_REGS; i++) words[i] <= cfg_data[32*i +: 32];
            verify_q      <= verify_en;
            idx           <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
            err_code      <= '0;
            err_index     <= '0;
            m_axi_awaddr  <= reg_addr(4'd0);
            m_axi_wdata   <= cfg_data[31:0];
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            timer         <= '0;
            state         <= ST_WR;
          end
        end
        ST_WR: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            m_axi_bready <= 1'b1;
            timer        <= '0;
            state        <= ST_WR_RESP;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        ST_WR_RESP: begin
          if (b_fire) begin
            m_axi_bready <= 1'b0;
            timer        <= '0;
            if (verify_q) begin
              m_axi_araddr  <= m_axi_awaddr;
              m_axi_arvalid <= 1'b1;
              state         <= ST_RD_ADDR;
            end else begin
              state <= ST_NEXT;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end
        ST_RD_ADDR: begin
          if (ar_fire) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            timer         <= '0;
            state         <= ST_RD_DATA;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        ST_RD_DATA: begin
          if (r_fire) begin
            m_axi_rready <= 1'b0;
            state        <= ST_NEXT;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        ST_NEXT: begin
          if (idx == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            error <= 1'b0;
            state <= ST_FIN;
          end else begin
            idx           <= idx_inc;
            m_axi_awaddr  <= reg_addr(idx_inc);
            m_axi_wdata   <= next_word;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            timer         <= '0;
            state         <= ST_WR;
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_10g_cfg_sequencer.sv
// tb_eth_10g_cfg_sequencer
//   Drives the sequencer against a reactive AXI4-Lite slave model with
//   configurable per-channel wait states and fault injection, and compares
//   each sequence with an outcome/cycle-count model derived from the rules.
module tb_eth_10g_cfg_sequencer;

  localparam int          NREG = 4;
  localparam int          TMO  = 16;
  localparam logic [31:0] BASE = 32'h0;

  logic                clk = 1'b0;
  logic                ARESETN;
  logic                start, verify_en;
  logic [NREG*32-1:0]  cfg_data;
  logic                busy, done, error;
  logic [1:0]          err_code;
  logic [3:0]          err_index;
  logic [31:0]         awaddr, wdata, araddr, rdata;
  logic [2:0]          awprot, arprot;
  logic [3:0]          wstrb;
  logic                awvalid, awready, wvalid, wready, bvalid, bready;
  logic                arvalid, arready, rvalid, rready;
  logic [1:0]          bresp, rresp;

  always #5 clk = ~clk;

  eth_10g_cfg_sequencer #(
    .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .NUM_REGS(NREG),
    .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .ACLK(clk), .ARESETN(ARESETN), .start(start), .verify_en(verify_en),
    .cfg_data(cfg_data), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .err_index(err_index),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
    .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready)
  );

  int n_vec = 0;
  int n_err = 0;

  // Slave configuration (written by the stimulus, read by the slave).
  int aw_delay = 0, w_delay = 0, b_fault = -1, r_fault = -1;
  bit b_enable = 1'b1;

  // Bus monitor: handshake logs and valid/ready high-cycle counters.
  logic [31:0] aw_log[$], w_log[$], ar_log[$];
  int b_n = 0, r_n = 0, aw_hi = 0, w_hi = 0, br_hi = 0, rr_hi = 0;

  always @(posedge clk) begin
    if (!ARESETN) begin
      aw_log.delete(); w_log.delete(); ar_log.delete();
      b_n = 0; r_n = 0;
    end else begin
      if (awvalid && awready) aw_log.push_back(awaddr);
      if (wvalid && wready)   w_log.push_back(wdata);
      if (arvalid && arready) ar_log.push_back(araddr);
      if (bvalid && bready)   b_n++;
      if (rvalid && rready)   r_n++;
      if (awvalid) aw_hi++;
      if (wvalid)  w_hi++;
      if (bready)  br_hi++;
      if (rready)  rr_hi++;
    end
  end

  // Slave driver: updates its outputs on the falling edge.
  int          aw_wait = 0, w_wait = 0, b_issued = 0, r_issued = 0, drv_idx = 0;
  logic [31:0] mem [16];
  logic [31:0] drv_off;

  always @(negedge clk) begin
    if (!ARESETN) begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
      aw_wait = 0; w_wait = 0; b_issued = 0; r_issued = 0;
    end else begin
      if (awvalid && !awready) begin
        if (aw_wait >= aw_delay) awready = 1'b1; else aw_wait++;
      end else begin
        awready = 1'b0; aw_wait = 0;
      end
      if (wvalid && !wready) begin
        if (w_wait >= w_delay) wready = 1'b1; else w_wait++;
      end else begin
        wready = 1'b0; w_wait = 0;
      end
      if (bvalid && b_n == b_issued) bvalid = 1'b0;
      if (!bvalid && b_enable && b_issued < aw_log.size() && b_issued < w_log.size()) begin
        drv_off = aw_log[b_issued] - BASE;
        drv_idx = int'(drv_off[5:2]);
        mem[drv_idx] = w_log[b_issued];
        bresp = (drv_idx == b_fault) ? 2'b10 : 2'b00;
        bvalid = 1'b1;
        b_issued++;
      end
      arready = (arvalid && !arready);
      if (rvalid && r_n == r_issued) rvalid = 1'b0;
      if (!rvalid && r_issued < ar_log.size()) begin
        drv_off = ar_log[r_issued] - BASE;
        drv_idx = int'(drv_off[5:2]);
        rdata = (drv_idx == r_fault) ? 32'hDEAD : mem[drv_idx];
        rresp = 2'b00;
        rvalid = 1'b1;
        r_issued++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2 ARESETN = 1'b0;
    @(negedge clk);
    #2 ARESETN = 1'b1;
  endtask

  // One complete sequence: reference outcome, stimulus, and checks.
  task automatic run_seq(input string tag, input logic [NREG*32-1:0] words, input bit ver,
                         input int da, input int dw, input int bf, input int rf, input bit ben);
    int per_wr, exp_cyc, exp_code, exp_idx, nw, nr, exp_bhi, cyc;
    int b_aw, b_w, b_ar, b_b, b_r, b_awhi, b_whi, b_brhi, b_rrhi;
    bit stop;
    logic [31:0] wd;

    // Reference: walk the registers in order, stop at the first failure.
    per_wr  = ((da > dw) ? da : dw) + 1;
    exp_cyc = 0; exp_code = 0; exp_idx = 0; nw = 0; nr = 0; exp_bhi = 0; stop = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (!stop) begin
        wd = words[32*i +: 32];
        nw++;
        exp_cyc += per_wr;
        if (!ben) begin
          exp_cyc += TMO; exp_bhi += TMO; exp_code = 3; exp_idx = i; stop = 1'b1;
        end else begin
          exp_cyc += 1; exp_bhi += 1;
          if (i == bf) begin
            exp_code = 1; exp_idx = i; stop = 1'b1;
          end else begin
            if (ver) begin
              nr++;
              exp_cyc += 2;
              if (i == rf && wd != 32'hDEAD) begin
                exp_code = 2; exp_idx = i; stop = 1'b1;
              end
            end
            if (!stop) exp_cyc += 1;
          end
        end
      end
    end

    @(negedge clk);
    aw_delay = da; w_delay = dw; b_fault = bf; r_fault = rf; b_enable = ben;
    b_aw = aw_log.size(); b_w = w_log.size(); b_ar = ar_log.size(); b_b = b_n; b_r = r_n;
    b_awhi = aw_hi; b_whi = w_hi; b_brhi = br_hi; b_rrhi = rr_hi;
    cfg_data = words; verify_en = ver; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy_on"}, 32'(busy), 32'd1);
    chk({tag, ".done_clr"}, 32'(done), 32'd0);
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".cycles"}, cyc, exp_cyc);
    chk({tag, ".busy_off"}, 32'(busy), 32'd0);
    chk({tag, ".error"}, 32'(error), (exp_code != 0) ? 32'd1 : 32'd0);
    chk({tag, ".err_code"}, 32'(err_code), exp_code);
    chk({tag, ".err_index"}, 32'(err_index), exp_idx);
    chk({tag, ".n_aw"}, aw_log.size() - b_aw, nw);
    chk({tag, ".n_w"}, w_log.size() - b_w, nw);
    chk({tag, ".n_ar"}, ar_log.size() - b_ar, nr);
    chk({tag, ".n_b"}, b_n - b_b, ben ? nw : 0);
    chk({tag, ".n_r"}, r_n - b_r, nr);
    chk({tag, ".awvalid_cyc"}, aw_hi - b_awhi, nw * (da + 1));
    chk({tag, ".wvalid_cyc"}, w_hi - b_whi, nw * (dw + 1));
    chk({tag, ".bready_cyc"}, br_hi - b_brhi, exp_bhi);
    chk({tag, ".rready_cyc"}, rr_hi - b_rrhi, nr);
    for (int i = 0; i < nw; i++) begin
      chk($sformatf("%s.awaddr%0d", tag, i), aw_log[b_aw + i], BASE + 32'(4 * i));
      chk($sformatf("%s.wdata%0d", tag, i), w_log[b_w + i], words[32*i +: 32]);
    end
    for (int i = 0; i < nr; i++)
      chk($sformatf("%s.araddr%0d", tag, i), ar_log[b_ar + i], BASE + 32'(4 * i));
    chk({tag, ".bus_idle"}, 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);

    // Start during the FIN->IDLE cycle must be ignored; status holds.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({tag, ".hold_busy"}, 32'(busy), 32'd0);
    chk({tag, ".hold_done"}, 32'(done), 32'd1);
    chk({tag, ".hold_code"}, 32'(err_code), exp_code);
    chk({tag, ".hold_no_aw"}, aw_log.size() - b_aw, nw);
    $display("seq %s: verify=%0d aw_wait=%0d w_wait=%0d -> code=%0d idx=%0d cycles=%0d",
             tag, ver, da, dw, err_code, err_index, cyc);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREG*32-1:0] w;
    int kind, fi;

    ARESETN = 1'b0; start = 1'b0; verify_en = 1'b0; cfg_data = '0;
    #12;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.error", 32'(error), 32'd0);
    chk("rst.err", 32'({err_code, err_index}), 32'd0);
    chk("rst.valids", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
    chk("rst.awaddr", awaddr, 32'd0);
    chk("rst.wdata", wdata, 32'd0);
    chk("rst.araddr", araddr, 32'd0);
    chk("rst.prot_strb", 32'({awprot, arprot, wstrb}), 32'h00F);
    @(negedge clk);
    #2 ARESETN = 1'b1;

    run_seq("t1", {32'd4, 32'd3, 32'd2, 32'd1}, 1'b1, 0, 0, -1, -1, 1'b1);
    run_seq("t2", {$urandom, $urandom, $urandom, $urandom}, 1'b1, 5, 0, -1, -1, 1'b1);
    run_seq("t3", {$urandom, $urandom, $urandom, $urandom}, 1'b1, 0, 0, 2, -1, 1'b1);
    run_seq("t4v", {$urandom, $urandom, $urandom, $urandom}, 1'b1, 0, 0, -1, 1, 1'b1);
    run_seq("t4n", {$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, 0, -1, 1, 1'b1);

    for (int t = 0; t < 12; t++) begin
      w    = {$urandom, $urandom, $urandom, $urandom};
      kind = int'($urandom_range(0, 2));
      fi   = int'($urandom_range(0, NREG - 1));
      run_seq($sformatf("rnd%0d", t), w, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              (kind == 1) ? fi : -1, (kind == 2) ? fi : -1, 1'b1);
    end

    run_seq("t5", {$urandom, $urandom, $urandom, $urandom}, 1'b1, 0, 0, -1, -1, 1'b0);
    reset_pulse();
    b_enable = 1'b1;

    // Reset asserted while the address phase is still waiting.
    @(negedge clk);
    aw_delay = 10; w_delay = 0; b_fault = -1; r_fault = -1;
    cfg_data = {$urandom, $urandom, $urandom, $urandom}; verify_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("t6.in_wr", 32'(awvalid), 32'd1);
    #2 ARESETN = 1'b0;
    #1;
    chk("t6.async_valids", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
    chk("t6.async_status", 32'({busy, done, error}), 32'd0);
    @(negedge clk);
    #2 ARESETN = 1'b1;
    run_seq("t6b", {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1, 2, -1, -1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
